// File: rtl/moore_steer.sv
// moore_steer
//   Stimulus-side companion for the 4-state Moore FSM (s0..s3, outputs 111/101/110/111).
//   Steers the FSM along the shortest path to a requested state by driving its a_in bus.
//   Keeps a shadow copy of the FSM state and checks the FSM's z_out against it.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   go         in   request a steer; accepted only while busy is low
//   target     in   requested FSM state, latched on accept
//   z_out      in   output code from the Moore FSM
//   a_in       out  registered input code to the Moore FSM
//   busy       out  steer in progress
//   done       out  one-cycle pulse when the shadow reaches the latched target
//   path_len   out  moves taken by the last steer, held until the next accept
//   shadow_st  out  shadow copy of the FSM state
//   err        out  sticky z_out mismatch flag
module moore_steer #(
   parameter logic [2:0]  NZ_CODE   = 3'b001,
   parameter int unsigned CHECK_LAG = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic [1:0] target,
   input  logic [2:0] z_out,
   output logic [2:0] a_in,
   output logic       busy,
   output logic       done,
   output logic [1:0] path_len,
   output logic [1:0] shadow_st,
   output logic       err
);

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;
   localparam logic [2:0] ChkStart = 3'(CHECK_LAG + 1);

   typedef enum logic {StIdle, StStep} state_e;

   // FSM transition: nz is 1 when a_in != 000
   function automatic logic [1:0] fsm_next(input logic [1:0] st, input logic nz);
      logic [1:0] nxt;
      case (st)
         S0, S1:  nxt = nz ? S2 : S0;
         S2:      nxt = nz ? S3 : S2;
         default: nxt = nz ? S3 : S1;
      endcase
      return nxt;
   endfunction

   function automatic logic [2:0] fsm_code(input logic [1:0] st);
      logic [2:0] code;
      case (st)
         S1:      code = 3'b101;
         S2:      code = 3'b110;
         default: code = 3'b111;
      endcase
      return code;
   endfunction

   // Shortest-path move from cur toward tgt; returns 1 for a nonzero move
   function automatic logic move_nz(input logic [1:0] cur, input logic [1:0] tgt);
      logic nz;
      case (tgt)
         S0:      nz = (cur == S2);
         S1, S2:  nz = (cur != S3);
         default: nz = 1'b1;
      endcase
      return nz;
   endfunction

   // Code that keeps the FSM where it is; s1 has none and falls back to 000
   function automatic logic [2:0] hold_code(input logic [1:0] st);
      return (st == S3) ? NZ_CODE : 3'b000;
   endfunction

   function automatic logic [2:0] drive_code(input logic nz);
      return nz ? NZ_CODE : 3'b000;
   endfunction

   state_e     state_q, state_d;
   logic [2:0] a_in_q, a_in_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [1:0] path_q, path_d;
   logic [1:0] shadow_q, shadow_d;
   logic [1:0] tgt_q, tgt_d;
   logic       err_q, err_d;
   logic [2:0] lag_cnt_q, lag_cnt_d;

   logic [2:0] exp_now;
   logic [2:0] exp_dly;
   logic       chk_en;

   // Steering and shadow next-state
   always_comb begin
      state_d  = state_q;
      a_in_d   = a_in_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      path_d   = path_q;
      tgt_d    = tgt_q;
      // Shadow follows the code actually on the bus this cycle
      shadow_d = fsm_next(shadow_q, |a_in_q);

      case (state_q)
         StIdle: begin
            a_in_d = hold_code(shadow_d);
            if (go) begin
               path_d = 2'd0;
               if (shadow_d == target) begin
                  done_d = 1'b1;
               end else begin
                  tgt_d   = target;
                  busy_d  = 1'b1;
                  state_d = StStep;
                  a_in_d  = drive_code(move_nz(shadow_d, target));
               end
            end
         end
         default: begin
            path_d = path_q + 2'd1;
            if (shadow_d == tgt_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
               a_in_d  = hold_code(shadow_d);
            end else begin
               a_in_d = drive_code(move_nz(shadow_d, tgt_q));
            end
         end
      endcase
   end

   // Check pipe: z_out is compared with the shadow's code from CHECK_LAG cycles ago
   assign exp_now = fsm_code(shadow_q);

   if (CHECK_LAG == 0) begin : g_no_lag
      assign exp_dly = exp_now;
   end else begin : g_lag
      logic [2:0] pipe_q [CHECK_LAG];
      logic [2:0] pipe_d [CHECK_LAG];

      always_comb begin
         pipe_d[0] = exp_now;
         for (int i = 1; i < int'(CHECK_LAG); i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end

      always_ff @(posedge clock) begin
         for (int i = 0; i < int'(CHECK_LAG); i++) begin
            if (reset) begin
               pipe_q[i] <= 3'b000;
            end else begin
               pipe_q[i] <= pipe_d[i];
            end
         end
      end

      assign exp_dly = pipe_q[CHECK_LAG-1];
   end

   // Comparison is enabled only once the pipe holds post-reset data
   assign chk_en    = (lag_cnt_q == ChkStart);
   assign lag_cnt_d = chk_en ? lag_cnt_q : lag_cnt_q + 3'd1;
   assign err_d     = err_q | (chk_en & (z_out != exp_dly));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         a_in_q    <= 3'b000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         path_q    <= 2'd0;
         shadow_q  <= S0;
         tgt_q     <= S0;
         err_q     <= 1'b0;
         lag_cnt_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         a_in_q    <= a_in_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         path_q    <= path_d;
         shadow_q  <= shadow_d;
         tgt_q     <= tgt_d;
         err_q     <= err_d;
         lag_cnt_q <= lag_cnt_d;
      end
   end

   assign a_in      = a_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign path_len  = path_q;
   assign shadow_st = shadow_q;
   assign err       = err_q;

endmodule

// File: tb/tb_moore_steer.sv
// tb_moore_steer
//   Directed bench for moore_steer. A behavioural Moore FSM with a one-cycle registered
//   output drives z_out (matching CHECK_LAG=1); z_out can be overridden to inject errors.
//   Observed vector layout: {busy, done, path_len, shadow_st, a_in, err}.
module tb_moore_steer;

   logic       clock = 1'b0;
   logic       reset;
   logic       go;
   logic [1:0] target;
   logic [2:0] z_out;
   logic [2:0] a_in;
   logic       busy;
   logic       done;
   logic [1:0] path_len;
   logic [1:0] shadow_st;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   moore_steer #(
      .NZ_CODE   (3'b001),
      .CHECK_LAG (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .go        (go),
      .target    (target),
      .z_out     (z_out),
      .a_in      (a_in),
      .busy      (busy),
      .done      (done),
      .path_len  (path_len),
      .shadow_st (shadow_st),
      .err       (err)
   );

   // Plant: the Moore FSM being steered, with its output registered once
   logic [1:0] plant_q;
   logic [2:0] plant_z_q;
   logic       force_en;
   logic [2:0] force_val;

   function automatic logic [1:0] plant_next(input logic [1:0] st, input logic nz);
      case (st)
         2'd0, 2'd1: return nz ? 2'd2 : 2'd0;
         2'd2:       return nz ? 2'd3 : 2'd2;
         default:    return nz ? 2'd3 : 2'd1;
      endcase
   endfunction

   function automatic logic [2:0] plant_code(input logic [1:0] st);
      case (st)
         2'd1:    return 3'b101;
         2'd2:    return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         plant_q   <= 2'd0;
         plant_z_q <= 3'b111;
      end else begin
         plant_q   <= plant_next(plant_q, a_in != 3'b000);
         plant_z_q <= plant_code(plant_q);
      end
   end

   assign z_out = force_en ? force_val : plant_z_q;

   logic [9:0] obs;
   assign obs = {busy, done, path_len, shadow_st, a_in, err};

   // Inputs applied before an edge, outputs expected after it
   typedef struct packed {
      logic       go;
      logic [1:0] tgt;
      logic [9:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      go    = 1'b0;
      tick();
      tick();
      n_tests++;
      if (obs !== 10'b0_0_00_00_000_0) begin
         n_fail++;
         $display("FAIL reset_values: got %b want %b", obs, 10'b0_0_00_00_000_0);
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if (obs !== 10'b0_0_00_00_000_0) begin
         n_fail++;
         $display("FAIL reset_idle_hold: got %b want %b", obs, 10'b0_0_00_00_000_0);
      end
   endtask

   task automatic test_zero_path();
      vec_t v [2];
      v = '{'{1'b1, 2'd0, {1'b0, 1'b1, 2'd0, 2'd0, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0}}};
      for (int i = 0; i < 2; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL zero_path[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_to_s3();
      vec_t v [4];
      v = '{'{1'b1, 2'd3, {1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd1, 2'd2, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd2, 2'd3, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd2, 2'd3, 3'b001, 1'b0}}};
      for (int i = 0; i < 4; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL to_s3[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_to_s1();
      vec_t v [4];
      v = '{'{1'b1, 2'd1, {1'b1, 1'b0, 2'd0, 2'd3, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd1, 2'd1, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd1, 2'd0, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd1, 2'd0, 3'b000, 1'b0}}};
      for (int i = 0; i < 4; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL to_s1[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_s2_to_s0();
      vec_t v [8];
      v = '{'{1'b1, 2'd2, {1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd1, 2'd2, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd1, 2'd2, 3'b000, 1'b0}},
            '{1'b1, 2'd0, {1'b1, 1'b0, 2'd0, 2'd2, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd1, 2'd3, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd2, 2'd1, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd3, 2'd0, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd3, 2'd0, 3'b000, 1'b0}}};
      for (int i = 0; i < 8; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL s2_to_s0[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_go_ignored();
      vec_t v [4];
      v = '{'{1'b1, 2'd3, {1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b0}},
            '{1'b1, 2'd0, {1'b1, 1'b0, 2'd1, 2'd2, 3'b001, 1'b0}},
            '{1'b1, 2'd1, {1'b0, 1'b1, 2'd2, 2'd3, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd2, 2'd3, 3'b001, 1'b0}}};
      for (int i = 0; i < 4; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL go_ignored[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_back_to_back();
      vec_t v [9];
      v = '{'{1'b1, 2'd1, {1'b1, 1'b0, 2'd0, 2'd3, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd1, 2'd1, 3'b000, 1'b0}},
            '{1'b1, 2'd3, {1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd1, 2'd2, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd2, 2'd3, 3'b001, 1'b0}},
            '{1'b1, 2'd2, {1'b1, 1'b0, 2'd0, 2'd3, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd1, 2'd1, 3'b001, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b1, 2'd2, 2'd2, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd2, 2'd2, 3'b000, 1'b0}}};
      for (int i = 0; i < 9; i++) begin
         go = v[i].go; target = v[i].tgt;
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      go = 1'b0;
   endtask

   task automatic test_err();
      logic exp_err [4];
      vec_t v [5];
      reset = 1'b1;
      go    = 1'b0;
      tick();
      tick();
      reset     = 1'b0;
      force_en  = 1'b1;
      force_val = 3'b101;
      // Two unchecked cycles after reset, then the mismatch must land
      exp_err = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         if (i == 3) force_en = 1'b0;
         tick();
         n_tests++;
         if (err !== exp_err[i]) begin
            n_fail++;
            $display("FAIL err_flag[%0d]: got %b want %b", i, err, exp_err[i]);
         end
      end
      // Steering continues with err set; reset mid-STEP aborts and clears everything
      v = '{'{1'b1, 2'd3, {1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b1}},
            '{1'b0, 2'd0, {1'b1, 1'b0, 2'd1, 2'd2, 3'b001, 1'b1}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0}},
            '{1'b0, 2'd0, {1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0}}};
      for (int i = 0; i < 5; i++) begin
         go = v[i].go; target = v[i].tgt;
         reset = (i == 2);
         tick();
         n_tests++;
         if (obs !== v[i].exp) begin
            n_fail++;
            $display("FAIL err_abort[%0d]: got %b want %b", i, obs, v[i].exp);
         end
      end
      reset = 1'b0;
      go    = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      go        = 1'b0;
      target    = 2'd0;
      force_en  = 1'b0;
      force_val = 3'b000;
      test_reset();
      test_zero_path();
      test_to_s3();
      test_to_s1();
      test_s2_to_s0();
      test_go_ignored();
      test_back_to_back();
      test_err();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
